// File: rtl/seq_multiplier_if.sv
// Operand/result handshake bundle between the host FSM and seq_multiplier.
// signed_op exists only when SEQ_MULT_SIGNED_EN is defined.
interface seq_multiplier_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
`ifdef SEQ_MULT_SIGNED_EN
    logic                 signed_op;
`endif
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

`ifdef SEQ_MULT_SIGNED_EN
    modport master (
        output start, multiplicand, multiplier, signed_op,
        input  ready, busy, done, product
    );
    modport slave (
        input  start, multiplicand, multiplier, signed_op,
        output ready, busy, done, product
    );
`else
    modport master (
        output start, multiplicand, multiplier,
        input  ready, busy, done, product
    );
    modport slave (
        input  start, multiplicand, multiplier,
        output ready, busy, done, product
    );
`endif
endinterface

// File: rtl/seq_multiplier.sv
// Shift-add sequential multiplier with zero bypass, early exit and held product.
// Define SEQ_MULT_SIGNED_EN to add two's-complement operation via signed_op.
module seq_multiplier #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    seq_multiplier_if.slave  bus
);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned CNT_W  = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e              state_q;
    logic [PROD_W-1:0]   acc_q;
    logic [PROD_W-1:0]   mcand_sh_q;
    logic [WIDTH-1:0]    mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [PROD_W-1:0]   product_q;

    logic [WIDTH-1:0]    a_mag_c;
    logic [WIDTH-1:0]    b_mag_c;
    logic [PROD_W-1:0]   acc_d;
    logic [PROD_W-1:0]   product_d;
    logic                last_c;

`ifdef SEQ_MULT_SIGNED_EN
    logic                neg_c;
    logic                sign_q;

    // Magnitudes and result sign of the operands presented for capture.
    always_comb begin
        a_mag_c = bus.multiplicand;
        b_mag_c = bus.multiplier;
        neg_c   = 1'b0;
        if (bus.signed_op) begin
            if (bus.multiplicand[WIDTH-1]) a_mag_c = ~bus.multiplicand + WIDTH'(1);
            if (bus.multiplier[WIDTH-1])   b_mag_c = ~bus.multiplier + WIDTH'(1);
            neg_c = bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1];
        end
    end
`else
    always_comb begin
        a_mag_c = bus.multiplicand;
        b_mag_c = bus.multiplier;
    end
`endif

    // One shift-add step; the exit test looks at the multiplier after this shift.
    always_comb begin
        acc_d  = acc_q + (mplier_q[0] ? mcand_sh_q : '0);
        last_c = ((mplier_q >> 1) == '0) || (cnt_q == CNT_W'(WIDTH - 1));
`ifdef SEQ_MULT_SIGNED_EN
        product_d = (sign_q && (acc_d != '0)) ? (~acc_d + PROD_W'(1)) : acc_d;
`else
        product_d = acc_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            mcand_sh_q <= '0;
            mplier_q   <= '0;
            cnt_q      <= '0;
            product_q  <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            sign_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        acc_q <= '0;
                        if ((a_mag_c == '0) || (b_mag_c == '0)) begin
                            product_q <= '0;
                            state_q   <= S_DONE;
                        end else begin
                            mcand_sh_q <= PROD_W'(a_mag_c);
                            mplier_q   <= b_mag_c;
                            cnt_q      <= '0;
`ifdef SEQ_MULT_SIGNED_EN
                            sign_q     <= neg_c;
`endif
                            state_q    <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    acc_q      <= acc_d;
                    mcand_sh_q <= mcand_sh_q << 1;
                    mplier_q   <= mplier_q >> 1;
                    cnt_q      <= cnt_q + CNT_W'(1);
                    if (last_c) begin
                        product_q <= product_d;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = (state_q == S_IDLE);
    assign bus.busy    = (state_q == S_RUN);
    assign bus.done    = (state_q == S_DONE);
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed cases with literal results, then random traffic
// checked every cycle against an arithmetic model of result and latency.
module tb_seq_multiplier;
    localparam int unsigned W  = 8;
    localparam int unsigned PW = 2 * W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sop = 1'b0;
    logic chk_en = 1'b0;
    int   total = 0;
    int   bad = 0;

    seq_multiplier_if #(.WIDTH(W)) bus ();
`ifdef SEQ_MULT_SIGNED_EN
    assign bus.signed_op = sop;
`endif

    seq_multiplier #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Result and run length straight from the arithmetic definition.
    function automatic void calc(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                 output logic [PW-1:0] p, output int k);
        longint sa, sb, mb;
        sa = s ? longint'($signed(a)) : longint'(a);
        sb = s ? longint'($signed(b)) : longint'(b);
        p  = PW'(sa * sb);
        mb = (sb < 0) ? -sb : sb;
        k  = 0;
        while (mb > 0) begin
            k++;
            mb = mb >>> 1;
        end
    endfunction

    // Reference timeline: cycles of RUN left, pending done, and held product.
    int              m_run_left = 0;
    logic            m_done = 1'b0;
    logic [PW-1:0]   m_prod = '0;
    logic [PW-1:0]   m_pending = '0;

    always @(posedge clk) begin
        logic [PW-1:0] p;
        int k;
        if (reset) begin
            m_run_left = 0;
            m_done     = 1'b0;
            m_prod     = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_run_left > 0) begin
            m_run_left--;
            if (m_run_left == 0) begin
                m_done = 1'b1;
                m_prod = m_pending;
            end
        end else if (bus.start) begin
            calc(bus.multiplicand, bus.multiplier, sop, p, k);
            if (bus.multiplicand == '0 || bus.multiplier == '0) begin
                m_done = 1'b1;
                m_prod = '0;
            end else begin
                m_run_left = k;
                m_pending  = p;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready",   64'(bus.ready),   64'(!m_done && m_run_left == 0));
            chk("busy",    64'(bus.busy),    64'(m_run_left > 0));
            chk("done",    64'(bus.done),    64'(m_done));
            chk("product", 64'(bus.product), 64'(m_prod));
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!bus.ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ready) chk("ready_timeout", 64'(0), 64'(1));
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        wait_ready();
        bus.start = 1'b1;
        bus.multiplicand = a;
        bus.multiplier = b;
        sop = s;
        @(negedge clk);
        bus.start = 1'b0;
        bus.multiplicand = W'($urandom);
        bus.multiplier = W'($urandom);
        sop = 1'($urandom);
    endtask

    // Bounded wait for done, then a short watch for any extra pulse.
    task automatic wait_done(output int bc, output logic [PW-1:0] p, output int dn);
        bool_seen: begin end
        bc = 0; dn = 0; p = '0;
        for (int i = 0; i < 60; i++) begin
            if (bus.busy) bc++;
            if (bus.done) begin
                dn++;
                p = bus.product;
                break;
            end
            @(negedge clk);
        end
        if (dn == 0) chk("done_timeout", 64'(0), 64'(1));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
    endtask

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, input logic [PW-1:0] exp_p, input int exp_busy);
        int bc, dn;
        logic [PW-1:0] p;
        issue(a, b, s);
        wait_done(bc, p, dn);
        chk({nm, "_product"}, 64'(p), 64'(exp_p));
        chk({nm, "_busy_cycles"}, 64'(bc), 64'(exp_busy));
        chk({nm, "_done_pulses"}, 64'(dn), 64'(1));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0:       return '0;
            1:       return W'($urandom % 4);
            2:       return ($urandom % 2) ? '1 : W'(1) << (W - 1);
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int bc, dn;
        logic [PW-1:0] p;
        bus.start = 1'b0;
        bus.multiplicand = '0;
        bus.multiplier = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        reset = 1'b0;
        chk("reset_ready", 64'(bus.ready), 64'(1));
        chk("reset_product", 64'(bus.product), 64'(0));

        run_op("13x11",   8'd13,  8'd11,  1'b0, 16'd143,   4);
        run_op("255x255", 8'd255, 8'd255, 1'b0, 16'hFE01,  8);
        run_op("0x200",   8'd0,   8'd200, 1'b0, 16'd0,     0);
        run_op("77x0",    8'd77,  8'd0,   1'b0, 16'd0,     0);

        // Start pulse during RUN cycle 3 must be ignored.
        issue(8'd5, 8'd128, 1'b0);
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        bus.multiplicand = 8'd3;
        bus.multiplier = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(bc, p, dn);
        chk("ignore_product", 64'(p), 64'(640));
        chk("ignore_done_pulses", 64'(dn), 64'(1));

        // Reset in RUN cycle 4 abandons the operation.
        issue(8'd200, 8'd200, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_ready", 64'(bus.ready), 64'(1));
        chk("abort_product", 64'(bus.product), 64'(0));
        dn = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        chk("abort_no_done", 64'(dn), 64'(0));
        run_op("2x3", 8'd2, 8'd3, 1'b0, 16'd6, 2);

`ifdef SEQ_MULT_SIGNED_EN
        run_op("s_m3x5",     8'hFD, 8'd5,  1'b1, 16'hFFF1, 3);
        run_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000, 8);
        run_op("s_m1x0",     8'hFF, 8'd0,  1'b1, 16'h0000, 0);
`endif

        // Random traffic, including starts while busy and rare resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom % 400) == 0;
            bus.start = ($urandom % 3) == 0;
            bus.multiplicand = pick();
            bus.multiplier = pick();
`ifdef SEQ_MULT_SIGNED_EN
            sop = 1'($urandom);
`else
            sop = 1'b0;
`endif
            @(negedge clk);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (15) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
